// File: rtl/lutram_fifo_ctrl.sv
// Address/control side of a 128-deep distributed-RAM FIFO.
// One registered output word on top of the RAM gives 129 words of capacity.
module lutram_fifo_ctrl #(
   parameter int WIDTH     = 8,
   parameter int AFULL_THR = 120
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             S_VALID,
   output logic             S_READY,
   input  logic [WIDTH-1:0] S_DATA,
   output logic             M_VALID,
   input  logic             M_READY,
   output logic [WIDTH-1:0] M_DATA,
   output logic [7:0]       LEVEL,
   output logic             AFULL,
   output logic             RAM_WE,
   output logic [6:0]       RAM_A,
   output logic [WIDTH-1:0] RAM_D,
   output logic [6:0]       RAM_DPRA,
   input  logic [WIDTH-1:0] RAM_DPO
);

   logic [6:0] wr_ptr;
   logic [6:0] rd_ptr;
   logic [7:0] ram_cnt;
   logic       push;
   logic       load;

   // Ready depends only on registered count, never on M_READY.
   assign S_READY  = (ram_cnt != 8'd128);
   assign push     = S_VALID && S_READY && RST_N;
   assign load     = (ram_cnt != 8'd0) && (!M_VALID || M_READY);

   assign RAM_WE   = push;
   assign RAM_A    = wr_ptr;
   assign RAM_D    = S_DATA;
   assign RAM_DPRA = rd_ptr;

   assign LEVEL    = ram_cnt + {7'd0, M_VALID};
   assign AFULL    = (LEVEL >= 8'(AFULL_THR));

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         ram_cnt <= '0;
         M_VALID <= 1'b0;
         M_DATA  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 7'd1;
         if (load) begin
            M_DATA  <= RAM_DPO;
            M_VALID <= 1'b1;
            rd_ptr  <= rd_ptr + 7'd1;
         end else if (M_VALID && M_READY) begin
            M_VALID <= 1'b0;
         end
         ram_cnt <= ram_cnt + {7'd0, push} - {7'd0, load};
      end
   end

endmodule

// File: tb/tb_lutram_fifo_ctrl.sv
// Bench for lutram_fifo_ctrl: RAM column model, order scoreboard,
// and directed status checks.
module tb_lutram_fifo_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         s_valid;
   logic         s_ready;
   logic [W-1:0] s_data;
   logic         m_valid;
   logic         m_ready;
   logic [W-1:0] m_data;
   logic [7:0]   level;
   logic         afull;
   logic         ram_we;
   logic [6:0]   ram_a;
   logic [W-1:0] ram_d;
   logic [6:0]   ram_dpra;
   logic [W-1:0] ram_dpo;

   logic [W-1:0] mem [128];

   int vectors = 0;
   int miscompares = 0;
   logic [W-1:0] expq[$];

   always #5 clk = ~clk;

   lutram_fifo_ctrl #(.WIDTH(W), .AFULL_THR(120)) dut (
      .CLK(clk), .RST_N(rst_n),
      .S_VALID(s_valid), .S_READY(s_ready), .S_DATA(s_data),
      .M_VALID(m_valid), .M_READY(m_ready), .M_DATA(m_data),
      .LEVEL(level), .AFULL(afull),
      .RAM_WE(ram_we), .RAM_A(ram_a), .RAM_D(ram_d),
      .RAM_DPRA(ram_dpra), .RAM_DPO(ram_dpo)
   );

   always @(posedge clk)
      if (ram_we) mem[ram_a] <= ram_d;
   assign ram_dpo = mem[ram_dpra];

   task automatic chk(input string nm, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Monitor: inputs are stable at negedge, so this sees the coming edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         expq.delete();
      end else begin
         if (m_valid && m_ready) begin
            if (expq.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL sb_extra: got %0h expected none", m_data);
            end else begin
               chk("sb_data", int'(m_data), int'(expq.pop_front()));
            end
         end
         if (s_valid && s_ready)
            expq.push_back(s_data);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int acc;
      int nxt;
      int cyc;
      rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      step(); step();
      rst_n = 1'b1;
      chk("rst_s_ready", int'(s_ready), 1);
      chk("rst_level", int'(level), 0);
      chk("rst_afull", int'(afull), 0);
      chk("rst_m_valid", int'(m_valid), 0);
      chk("rst_m_data", int'(m_data), 0);
      chk("rst_ram_we", int'(ram_we), 0);

      // Back-to-back 01..05 with consumer ready
      m_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         s_valid = 1'b1;
         s_data  = 8'(i + 1);
         step();
         chk("lat_m_valid", int'(m_valid), (i >= 1) ? 1 : 0);
         if (i >= 1) chk("lat_m_data", int'(m_data), i);
      end
      s_valid = 1'b0;
      step();
      chk("seq_m_data5", int'(m_data), 5);
      step(); step();
      chk("seq_level0", int'(level), 0);
      chk("seq_m_valid0", int'(m_valid), 0);

      // Fill with consumer stalled
      m_ready = 1'b0;
      acc = 0;
      cyc = 0;
      while (acc < 130 && cyc < 140) begin
         s_valid = 1'b1;
         s_data  = 8'(acc + 8'h20);
         if (s_ready) acc++;
         step();
         cyc++;
         if (acc == 119 && s_ready) chk("afull_119", int'(afull), 0);
         if (acc == 120 && s_ready) chk("afull_120", int'(afull), 1);
         if (acc == 129) break;
      end
      chk("fill_acc", acc, 129);
      chk("full_level", int'(level), 129);
      chk("full_afull", int'(afull), 1);
      chk("full_s_ready", int'(s_ready), 0);
      s_data = 8'(129 + 8'h20);
      step(); step(); step();
      chk("hold_level", int'(level), 129);
      chk("hold_s_ready", int'(s_ready), 0);
      chk("hold_m_data", int'(m_data), 8'h20);

      // One-cycle pop from full
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      chk("pop_m_data", int'(m_data), 8'h21);
      chk("pop_s_ready", int'(s_ready), 1);
      chk("pop_level", int'(level), 128);
      step();
      s_valid = 1'b0;
      chk("refill_level", int'(level), 129);
      chk("refill_s_ready", int'(s_ready), 0);

      m_ready = 1'b1;
      for (int i = 0; i < 135; i++) step();
      chk("drain_level", int'(level), 0);
      chk("drain_q", expq.size(), 0);

      // Random stream of 300 words
      nxt = 0;
      cyc = 0;
      while (nxt < 300 && cyc < 3000) begin
         s_valid = 1'($urandom_range(0, 1));
         m_ready = 1'($urandom_range(0, 1));
         s_data  = 8'(nxt * 7 + 3);
         if (s_valid && s_ready) nxt++;
         step();
         cyc++;
      end
      chk("rand_acc", nxt, 300);
      s_valid = 1'b0;
      m_ready = 1'b1;
      for (int i = 0; i < 135; i++) step();
      chk("rand_level", int'(level), 0);
      chk("rand_q", expq.size(), 0);

      // Hold at 64 with simultaneous push and pop
      m_ready = 1'b0;
      for (int i = 0; i < 64; i++) begin
         s_valid = 1'b1;
         s_data  = 8'(i + 8'h40);
         step();
      end
      chk("lvl64", int'(level), 64);
      m_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         s_data = 8'(i + 8'h90);
         step();
         chk("lvl64_steady", int'(level), 64);
      end
      s_valid = 1'b0;
      for (int i = 0; i < 14; i++) step();
      chk("lvl50", int'(level), 50);

      // Reset mid-operation with a push offered
      m_ready = 1'b0;
      rst_n   = 1'b0;
      s_valid = 1'b1;
      s_data  = 8'h77;
      #1;
      chk("rst_cyc_ram_we", int'(ram_we), 0);
      step();
      rst_n   = 1'b1;
      s_valid = 1'b0;
      chk("mid_level", int'(level), 0);
      chk("mid_m_valid", int'(m_valid), 0);
      chk("mid_m_data", int'(m_data), 0);
      chk("mid_s_ready", int'(s_ready), 1);
      s_valid = 1'b1;
      s_data  = 8'hA5;
      m_ready = 1'b1;
      step();
      s_valid = 1'b0;
      step();
      chk("a5_m_valid", int'(m_valid), 1);
      chk("a5_m_data", int'(m_data), 8'hA5);
      step(); step();
      chk("end_q", expq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
